// File: rtl/add_sub_arbiter_if.sv
// Bundle of every signal between the arbiter, its two requesters and the shared add_sub unit.
// Latency: none, this is wiring only. Backpressure: none here; the arbiter serialises requests.
// Ports: requester side req*/a*/b*/ctr* in, sum*/carry*/done* out; unit side au_a/au_b/au_ctr out, au_sum/au_carry in; busy.
interface add_sub_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             ctr0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             ctr1;

  logic [WIDTH-1:0] au_a;
  logic [WIDTH-1:0] au_b;
  logic             au_ctr;
  logic [WIDTH-1:0] au_sum;
  logic             au_carry;

  logic [WIDTH-1:0] sum0;
  logic             carry0;
  logic             done0;
  logic [WIDTH-1:0] sum1;
  logic             carry1;
  logic             done1;
  logic             busy;

  // Environment view: the requesters plus the shared unit's result path.
  modport master (
    output req0, a0, b0, ctr0, req1, a1, b1, ctr1, au_sum, au_carry,
    input  au_a, au_b, au_ctr, sum0, carry0, done0, sum1, carry1, done1, busy
  );

  // Arbiter view.
  modport slave (
    input  req0, a0, b0, ctr0, req1, a1, b1, ctr1, au_sum, au_carry,
    output au_a, au_b, au_ctr, sum0, carry0, done0, sum1, carry1, done1, busy
  );
endinterface

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sequencing two requesters onto one shared add_sub unit.
// Latency: request sampled in IDLE at T -> done pulse at T+2; one operation every 3 cycles.
// Backpressure: requests wait in IDLE; req inputs are ignored while busy (EXEC and DONE).
// Ports: clk, rst_n (async active-low), bus (slave modport of add_sub_arbiter_if).
module add_sub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  add_sub_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   sel;       // requester currently being served
  logic   rr;        // requester that wins when both ask
  logic   grant1;    // IDLE arbitration result: 1 selects requester 1

  // Requester 1 wins if it is alone, or if both ask and the pointer favours it.
  always_comb begin
    grant1 = 1'b0;
    if (bus.req1 && (!bus.req0 || rr)) begin
      grant1 = 1'b1;
    end
  end

  // au_a/au_b/au_ctr are the operand registers themselves, so the shared unit
  // sees stable inputs and they only move on a grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      rr         <= 1'b0;
      bus.au_a   <= '0;
      bus.au_b   <= '0;
      bus.au_ctr <= 1'b0;
      bus.sum0   <= '0;
      bus.carry0 <= 1'b0;
      bus.done0  <= 1'b0;
      bus.sum1   <= '0;
      bus.carry1 <= 1'b0;
      bus.done1  <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          if (bus.req0 || bus.req1) begin
            sel        <= grant1;
            bus.au_a   <= grant1 ? bus.a1   : bus.a0;
            bus.au_b   <= grant1 ? bus.b1   : bus.b0;
            bus.au_ctr <= grant1 ? bus.ctr1 : bus.ctr0;
            bus.busy   <= 1'b1;
            state      <= EXEC;
          end
        end

        EXEC: begin
          // Capture the unit's combinational result for the served requester
          // only; the other requester's result stays untouched.
          if (sel) begin
            bus.sum1   <= bus.au_sum;
            bus.carry1 <= bus.au_carry;
            bus.done1  <= 1'b1;
          end else begin
            bus.sum0   <= bus.au_sum;
            bus.carry0 <= bus.au_carry;
            bus.done0  <= 1'b1;
          end
          state <= DONE;
        end

        DONE: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.busy  <= 1'b0;
          rr        <= ~sel;
          state     <= IDLE;
        end

        default: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/add_sub_arbiter.md
Name: add_sub_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for one shared add_sub datapath (WIDTH-bit operands a/b, CTR=0 add, CTR=1 subtract, sum/carry result).
- Latches the granted requester's operands and drives them onto the shared unit's inputs.
- Captures the unit's combinational result and returns it to that requester with a one-cycle done pulse.
- Sits between two independent operation sources and a single add_sub instance instantiated alongside it at the same level.

Parameters:
WIDTH, 4, operand/result width; must match the shared add_sub instance.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 operation request; held high with operands stable until done0
a0  input  WIDTH  requester 0 operand a
b0  input  WIDTH  requester 0 operand b
ctr0  input  1  requester 0 op select: 0 add, 1 subtract
req1  input  1  requester 1 operation request
a1  input  WIDTH  requester 1 operand a
b1  input  WIDTH  requester 1 operand b
ctr1  input  1  requester 1 op select
au_a  output  WIDTH  to shared unit a
au_b  output  WIDTH  to shared unit b
au_ctr  output  1  to shared unit CTR
au_sum  input  WIDTH  from shared unit sum
au_carry  input  1  from shared unit carry
sum0  output  WIDTH  registered result for requester 0
carry0  output  1  registered carry for requester 0
done0  output  1  one-cycle pulse: sum0/carry0 valid
sum1  output  WIDTH  registered result for requester 1
carry1  output  1  registered carry for requester 1
done1  output  1  one-cycle pulse: sum1/carry1 valid
busy  output  1  high in EXEC and DONE states

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; au_a/au_b/au_ctr, sum0/1, carry0/1, done0/1 and busy all 0; rr pointer 0 (requester 0 has priority). Reset mid-operation aborts it: no done pulse, captured results cleared.
- State IDLE:
  - Samples req0/req1. None: stay IDLE.
  - One request: grant it. Both: grant the requester selected by the rr pointer.
  - On grant edge, latch the granted a/b/ctr into operand registers and record sel; go to EXEC.
- State EXEC (one cycle): au_a/au_b/au_ctr are driven from the operand registers. At the end edge, au_sum/au_carry are captured into sum_sel/carry_sel; go to DONE.
- State DONE (one cycle):
  - done_sel = 1 for exactly this cycle; rr pointer set to the other requester; go to IDLE.
  - req inputs are ignored in EXEC and DONE.
- Latency: request seen in IDLE at cycle T -> done at T+2. Throughput: one operation per 3 cycles. The next grant is at the earliest T+3.
- Requester handshake: keep req and operands stable until done. Drop req in the done cycle to avoid a repeat. If req is still high in the following IDLE cycle, it is a new operation.
- Operand registers (au_*) hold their last value outside EXEC. They change only on a grant edge.
- sum_i/carry_i hold their value until the next capture for that requester. The other requester's result is never disturbed.
- The arbiter does not interpret the carry. au_carry is passed through unchanged, including its subtract semantics. Overflow wrap is as produced by the unit.
- Fairness: with both req held continuously, grants strictly alternate (0,1,0,1...).

Test Plan:
- Reset, then req0 with a0=0011, b0=0101, ctr0=0 -> au_a=0011 in EXEC; done0 two cycles after the grant cycle, sum0=1000, carry0=0; done1 stays 0.
- req1 with a1=0101, b1=0011, ctr1=1 -> sum1=0010, carry1=1 (as returned by the unit), done1 one-cycle pulse; sum0 unchanged from the prior op.
- Wrap-around: req0 with 1111+0001 add -> sum0=0000, carry0=1.
- req0 and req1 raised together after reset -> requester 0 served first (done0), then requester 1 (done1 three cycles later). Repeat both with the pointer now at 0 -> 0 then 1. Holding both for 6 ops gives grants 0,1,0,1,0,1.
- Requester holds req through the done cycle -> a second identical operation is issued at the next IDLE cycle and done pulses again 3 cycles later.
- rst_n pulsed low during EXEC -> no done pulse; all outputs 0 immediately. After release, the pending req0 is granted normally.
